// File: rtl/batch_accumulator.sv
// batch_accumulator: collects COUNT unsigned operands over a valid/ready
// handshake and sums them with a ripple-carry adder. The final sum and a
// sticky carry-out are held in DONE until the consumer acknowledges.
module batch_accumulator #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  input  logic             done_ack,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    count_inc;
  logic             accept;

  // Ripple-carry chain: registered sum plus incoming operand
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] add_sum;

  assign carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_rca
      assign add_sum[gi]   = sum_q[gi] ^ din[gi] ^ carry[gi];
      assign carry[gi + 1] = (sum_q[gi] & din[gi]) | (carry[gi] & (sum_q[gi] ^ din[gi]));
    end
  endgenerate

  // Ready whenever a batch can take an operand and no clear is pending
  always_comb begin
    in_ready = ((state_q == IDLE) || (state_q == ACCUM)) && !clear;
  end

  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + CW'(1);

  // Next-state and datapath decisions; clear overrides every other action
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    co_d    = co_q;
    done_d  = done_q;
    busy_d  = busy_q;
    count_d = count_q;

    if (clear) begin
      state_d = IDLE;
      sum_d   = '0;
      co_d    = 1'b0;
      count_d = '0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sum_d   = din;
            co_d    = 1'b0;
            count_d = CW'(1);
            if (COUNT == 1) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = ACCUM;
              busy_d  = 1'b1;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            sum_d   = add_sum;
            co_d    = co_q | carry[WIDTH];
            count_d = count_inc;
            if (count_inc == CW'(COUNT)) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
        DONE: begin
          if (done_ack) begin
            state_d = IDLE;
            done_d  = 1'b0;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          done_d  = 1'b0;
          busy_d  = 1'b0;
          count_d = '0;
        end
      endcase
    end
  end

  // State and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sum_q   <= '0;
      co_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign sum  = sum_q;
  assign co   = co_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
